// File: rtl/qmult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : qmult_arbiter
//  Purpose  : Round-robin arbiter that shares a single serial fixed-point
//             multiplier between four requesters. It accepts one request at a
//             time, drives the multiplier and returns the product on a shared
//             response channel.
//  Revision : 1.0 - initial release
//
//  Ports
//    i_clk, i_rst_n            clock, synchronous active-low reset
//    i_req_valid/i_req_a/b     per-requester request and operands
//                              (requester k uses slice [k*N +: N])
//    o_req_ready               one-hot accept
//    o_rsp_*, i_rsp_ready      shared response channel (id/data/ovf/err)
//    o_mul_*, i_mul_*          link to the shared serial multiplier
//    o_busy                    high whenever the arbiter is not idle
//
//  Build option
//    QMULT_ARB_TIMEOUT_EN      when defined, a transaction whose multiplier
//                              does not finish within N+8 cycles of the
//                              start pulse is answered with o_rsp_err=1.
// ============================================================================
module qmult_arbiter #(
    parameter int N = 32,
    parameter int Q = 15
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [3:0]     i_req_valid,
    input  logic [4*N-1:0] i_req_a,
    input  logic [4*N-1:0] i_req_b,
    output logic [3:0]     o_req_ready,
    output logic           o_rsp_valid,
    output logic [1:0]     o_rsp_id,
    output logic [N-1:0]   o_rsp_data,
    output logic           o_rsp_ovf,
    output logic           o_rsp_err,
    input  logic           i_rsp_ready,
    output logic [N-1:0]   o_mul_multiplicand,
    output logic [N-1:0]   o_mul_multiplier,
    output logic           o_mul_start,
    input  logic [N-1:0]   i_mul_result,
    input  logic           i_mul_complete,
    input  logic           i_mul_overflow,
    output logic           o_busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     rr_ptr_q, rr_ptr_d;
    logic [1:0]     id_q, id_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   data_q, data_d;
    logic           ovf_q, ovf_d;

    logic [N-1:0]   w_req_a [4];
    logic [N-1:0]   w_req_b [4];
    logic [1:0]     w_idx;
    logic [1:0]     w_gnt_id;
    logic           w_gnt_vld;
    logic           w_xfer;

    // Q describes the multiplier's number format only; the arbiter moves
    // operands and results untouched. This empty block just names the case
    // of a fractional field wider than the word.
    if (Q >= N) begin : g_q_exceeds_width
    end

    genvar k;
    for (k = 0; k < 4; k++) begin : g_unpack
        assign w_req_a[k] = i_req_a[k*N +: N];
        assign w_req_b[k] = i_req_b[k*N +: N];
    end

    // Round-robin search: scan from the highest offset down so the valid
    // requester closest to rr_ptr (wrapping 3->0) is the one left selected.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = rr_ptr_q;
        w_idx     = rr_ptr_q;
        for (int off = 3; off >= 0; off--) begin
            w_idx = rr_ptr_q + 2'(off);
            if (i_req_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_idx;
            end
        end
    end

    // Grants only while idle and the multiplier reports itself finished; the
    // multiplier is not reset with us, so after a reset it may still be busy.
    assign o_req_ready = (i_rst_n && state_q == IDLE && i_mul_complete && w_gnt_vld)
                         ? (4'b0001 << w_gnt_id) : 4'b0000;
    assign w_xfer      = |(o_req_ready & i_req_valid);

`ifdef QMULT_ARB_TIMEOUT_EN
    localparam int              TO_W    = $clog2(N + 8);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(N + 7);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
    logic            w_to_expired;

    // Counter reads 0 in the ISSUE cycle and k in the k-th cycle after it.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == IDLE) begin
            to_cnt_d = '0;
        end else if (state_q != RESP) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    assign w_to_expired = (to_cnt_q == TO_LAST);
    assign o_rsp_err    = err_q;
`else
    assign o_rsp_err    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
`ifdef QMULT_ARB_TIMEOUT_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_xfer) begin
                    a_d      = w_req_a[w_gnt_id];
                    b_d      = w_req_b[w_gnt_id];
                    id_d     = w_gnt_id;
                    rr_ptr_d = w_gnt_id + 2'd1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                // complete is still high from the previous operation until
                // the multiplier has seen the start pulse.
`ifdef QMULT_ARB_TIMEOUT_EN
                if (w_to_expired) begin
                    data_d  = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else
`endif
                if (!i_mul_complete) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_mul_complete) begin
                    data_d  = i_mul_result;
                    ovf_d   = i_mul_overflow;
`ifdef QMULT_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end
`ifdef QMULT_ARB_TIMEOUT_EN
                else if (w_to_expired) begin
                    data_d  = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= 2'd0;
            id_q     <= 2'd0;
            a_q      <= '0;
            b_q      <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
`ifdef QMULT_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
`ifdef QMULT_ARB_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign o_mul_multiplicand = a_q;
    assign o_mul_multiplier   = b_q;
    assign o_mul_start        = (state_q == ISSUE);
    assign o_rsp_valid        = (state_q == RESP);
    assign o_rsp_id           = id_q;
    assign o_rsp_data         = data_q;
    assign o_rsp_ovf          = ovf_q;
    assign o_busy             = (state_q != IDLE);

endmodule
`default_nettype wire
